// File: rtl/jtdsp16_pio_mc.sv
// rtl/jtdsp16_pio_mc.sv - multi-channel parallel I/O port with write FIFO, read slot and interrupt latch
module jtdsp16_pio_mc #(
    parameter  int DW     = 16,
    parameter  int NCH    = 2,
    parameter  int FDEPTH = 4,
    localparam int CW     = $clog2(NCH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ph1,
    input  logic [DW-1:0] pbus_in,
    output logic [DW-1:0] pbus_out,
    output logic          pods_n,
    output logic          pids_n,
    output logic [CW-1:0] psel,
    input  logic          irq,
    input  logic          cfg_we,
    input  logic [7:0]    cfg_din,
    input  logic          wr_req,
    input  logic [CW-1:0] wr_ch,
    input  logic [DW-1:0] wr_data,
    output logic          wr_full,
    input  logic          rd_req,
    input  logic [CW-1:0] rd_ch,
    output logic          rd_busy,
    output logic [DW-1:0] rd_dout,
    output logic          rd_done,
    output logic [7:0]    status,
    input  logic          iack,
    output logic          irq_latch
);

    localparam int AW = $clog2(FDEPTH);
    localparam int LW = $clog2(FDEPTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q;
    logic          op_rd_q;
    logic [CW-1:0] psel_q;
    logic [DW-1:0] pbus_q;

    logic [CW-1:0] fifo_ch_q   [FDEPTH];
    logic [DW-1:0] fifo_data_q [FDEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q;

    logic          rd_pend_q;
    logic [CW-1:0] rd_ch_q;
    logic [DW-1:0] rd_dout_q;
    logic          rd_done_q;

    logic [7:0]    cfg_q;
    logic          overrun_q;

    logic          irq_q, iack_q, empty_q, irq_latch_q;

    logic          fifo_empty, fifo_full;
    logic          push, pop, start_rd, capture;
    logic          irq_set, iack_fall;
    logic [31:0]   level_w;
    logic [2:0]    level_sat;

    // FIFO flags and the per-cycle events that move data around
    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LW'(FDEPTH));
    assign push       = ph1 & wr_req & ~fifo_full;
    assign start_rd   = ph1 & (state_q == IDLE) & rd_pend_q;
    assign pop        = ph1 & (state_q == IDLE) & ~rd_pend_q & ~fifo_empty;
    assign capture    = ph1 & (state_q == STROBE) & (cnt_q == 4'd0) & op_rd_q;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else if (ph1) begin
            state_q <= state_d;
        end
    end

    // FSM next state: pending read outranks queued writes when leaving IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rd_pend_q || !fifo_empty) state_d = SETUP;
            SETUP:   state_d = STROBE;
            STROBE:  if (cnt_q == 4'd0) state_d = HOLD;
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: only STROBE drives a strobe, direction chosen by the running op
    always_comb begin
        pods_n = 1'b1;
        pids_n = 1'b1;
        if (state_q == STROBE) begin
            if (op_rd_q) pids_n = 1'b0;
            else         pods_n = 1'b0;
        end
    end

    // Transaction datapath: strobe counter, op direction, select and write data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= 4'd0;
            op_rd_q <= 1'b0;
            psel_q  <= '0;
            pbus_q  <= '0;
        end else if (ph1) begin
            if (start_rd) begin
                op_rd_q <= 1'b1;
                psel_q  <= rd_ch_q;
            end else if (pop) begin
                op_rd_q <= 1'b0;
                psel_q  <= fifo_ch_q[rd_ptr_q];
                pbus_q  <= fifo_data_q[rd_ptr_q];
            end
            // stlen is taken at STROBE entry so a mid-transaction cfg write only affects the next one
            if (state_q == SETUP) begin
                cnt_q <= cfg_q[3:0];
            end else if (state_q == STROBE && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    // FIFO storage; contents need no reset since the level gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_ch_q[wr_ptr_q]   <= wr_ch;
            fifo_data_q[wr_ptr_q] <= wr_data;
        end
    end

    // FIFO pointers and level; push and pop together leave the level unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Read slot: one outstanding read, freed when its data is captured
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend_q <= 1'b0;
            rd_ch_q   <= '0;
            rd_dout_q <= '0;
            rd_done_q <= 1'b0;
        end else if (ph1) begin
            rd_done_q <= capture;
            if (capture) begin
                rd_pend_q <= 1'b0;
                rd_dout_q <= pbus_in;
            end else if (rd_req && !rd_pend_q) begin
                rd_pend_q <= 1'b1;
                rd_ch_q   <= rd_ch;
            end
        end
    end

    // Config register and sticky overrun; a new overrun event beats a same-cycle clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_q     <= 8'd0;
            overrun_q <= 1'b0;
        end else if (ph1) begin
            if (cfg_we) begin
                cfg_q     <= cfg_din;
                overrun_q <= 1'b0;
            end
            if ((wr_req && fifo_full) || (rd_req && rd_pend_q)) begin
                overrun_q <= 1'b1;
            end
        end
    end

    // Interrupt sources compared against their ph1-registered copies
    assign irq_set   = (irq & ~irq_q & cfg_q[4])
                     | (fifo_empty & ~empty_q & cfg_q[5])
                     | (rd_done_q & cfg_q[6]);
    assign iack_fall = ~iack & iack_q;

    // Interrupt latch; set wins over a simultaneous acknowledge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q       <= 1'b0;
            iack_q      <= 1'b0;
            empty_q     <= 1'b1;
            irq_latch_q <= 1'b0;
        end else if (ph1) begin
            irq_q   <= irq;
            iack_q  <= iack;
            empty_q <= fifo_empty;
            if (irq_set) begin
                irq_latch_q <= 1'b1;
            end else if (iack_fall) begin
                irq_latch_q <= 1'b0;
            end
        end
    end

    // Status level field saturates at 7 for deep FIFOs
    assign level_w   = 32'(level_q);
    assign level_sat = (level_w > 32'd7) ? 3'd7 : level_w[2:0];

    assign pbus_out  = pbus_q;
    assign psel      = psel_q;
    assign wr_full   = fifo_full;
    assign rd_busy   = rd_pend_q;
    assign rd_dout   = rd_dout_q;
    assign rd_done   = rd_done_q;
    assign irq_latch = irq_latch_q;
    assign status    = {overrun_q, rd_pend_q, fifo_full, fifo_empty, 1'b0, level_sat};

endmodule
